// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle between the two masters, the arbiter and the memory
// control lines. The shared data bus uniBus stays a plain inout on the arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0, req1;
  logic              rw0, rw1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_start;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;
  logic              owner;

  // requesting side (CPU / loader, memory control observer)
  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1, mem_start, mem_rw, mem_addr, busy, owner
  );

  // arbiter side
  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1, mem_start, mem_rw, mem_addr, busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter/sequencer for the shared memory on uniBus.
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE, one operation at a time.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise
// port 0 has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  mem_bus_arbiter_if.slave  mbi,
  inout  wire  [DATA_W-1:0] uniBus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              r_owner;
  logic [3:0]        r_cnt;
  logic              w_any, w_win, w_start, w_ack0, w_ack1, w_drv;

  assign w_any = mbi.req0 | mbi.req1;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;
  // on conflict the port that was not served last wins
  assign w_win = (mbi.req0 & mbi.req1) ? ~r_last : mbi.req1;

  // last-granted port, recorded when the transaction completes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  r_last <= 1'b1;
    else if (r_state == S_DONE) r_last <= r_owner;
  end
`else
  // port 0 always wins; port 1 only when port 0 is quiet
  assign w_win = ~mbi.req0;
`endif

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next state and per-state pulses
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_ack0  = 1'b0;
    w_ack1  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: begin
        w_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
      S_DONE:  begin
        w_ack0 = ~r_owner;
        w_ack1 = r_owner;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, wait counter and read capture at the end of the last WAIT cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_data   <= '0;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_owner <= w_win;
          r_rw    <= w_win ? mbi.rw1    : mbi.rw0;
          r_addr  <= w_win ? mbi.addr1  : mbi.addr0;
          r_data  <= w_win ? mbi.wdata1 : mbi.wdata0;
        end
        S_ISSUE: r_cnt <= 4'(MEM_LAT);
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // rdata is loaded here so it is already valid during the DONE/ack cycle
          if (r_cnt == 4'd1 && r_rw) begin
            r_data <= uniBus;
            if (r_owner) r_rdata1 <= uniBus;
            else         r_rdata0 <= uniBus;
          end
        end
        default: ;
      endcase
    end
  end

  // write data goes on the bus only during ISSUE/WAIT of a write
  assign w_drv  = ~r_rw & ((r_state == S_ISSUE) | (r_state == S_WAIT));
  assign uniBus = w_drv ? r_data : {DATA_W{1'bz}};

  assign mbi.mem_start = w_start;
  assign mbi.mem_rw    = r_rw;
  assign mbi.mem_addr  = r_addr;
  assign mbi.ack0      = w_ack0;
  assign mbi.ack1      = w_ack1;
  assign mbi.rdata0    = r_rdata0;
  assign mbi.rdata1    = r_rdata1;
  assign mbi.busy      = (r_state != S_IDLE);
  assign mbi.owner     = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=4,
// each with a latency-accurate memory on its own pulled-up uniBus and a
// transaction-timeline model compared against every output on every cycle.
module tb_mem_bus_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic       t_rst [2];
  logic       t_req0[2], t_req1[2], t_rw0[2], t_rw1[2];
  logic [7:0] t_a0[2], t_a1[2], t_wd0[2], t_wd1[2];
  logic       o_start[2], o_ack0[2], o_ack1[2], o_busy[2];
  logic [7:0] o_rd0[2], o_rd1[2], o_bus[2];

  int n_start[2], n_ack0[2], n_ack1[2], n_busy[2];
  logic [7:0] bus_start[2];
  int grants[$];

  function automatic logic [7:0] init(int i);
    return 8'(i) ^ 8'h6E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 4;

    mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bif ();
    wire [7:0] bus;
    for (genvar b = 0; b < 8; b++) begin : gp
      pullup (bus[b]);
    end

    assign bif.req0   = t_req0[g];
    assign bif.req1   = t_req1[g];
    assign bif.rw0    = t_rw0[g];
    assign bif.rw1    = t_rw1[g];
    assign bif.addr0  = t_a0[g];
    assign bif.addr1  = t_a1[g];
    assign bif.wdata0 = t_wd0[g];
    assign bif.wdata1 = t_wd1[g];
    assign o_start[g] = bif.mem_start;
    assign o_ack0[g]  = bif.ack0;
    assign o_ack1[g]  = bif.ack1;
    assign o_busy[g]  = bif.busy;
    assign o_rd0[g]   = bif.rdata0;
    assign o_rd1[g]   = bif.rdata1;
    assign o_bus[g]   = bus;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(L)) dut (
      .CLK(CLK), .RST(t_rst[g]), .mbi(bif), .uniBus(bus)
    );

    // memory: drives read data during WAIT, commits writes at the last WAIT edge
    logic [7:0] mem [256];
    logic       m_pend, m_rw;
    logic [7:0] m_addr;
    int         m_cnt;
    always @(posedge CLK or negedge t_rst[g]) begin
      if (!t_rst[g]) begin
        m_pend <= 1'b0;
        m_rw   <= 1'b1;
        m_addr <= 8'h00;
        m_cnt  <= 0;
        for (int i = 0; i < 256; i++) mem[i] <= init(i);
      end else if (bif.mem_start) begin
        m_pend <= 1'b1;
        m_rw   <= bif.mem_rw;
        m_addr <= bif.mem_addr;
        m_cnt  <= L;
      end else if (m_pend) begin
        if (m_cnt == 1) begin
          m_pend <= 1'b0;
          if (!m_rw) mem[m_addr] <= bus;
        end else m_cnt <= m_cnt - 1;
      end
    end
    assign bus = (m_pend && m_rw) ? mem[m_addr] : 8'bz;

    // model: k = cycle index inside a transaction (1 ISSUE, 2..L+1 WAIT, L+2 DONE)
    initial begin : cmp
      int k;
      logic own, last, mrw;
      logic [7:0] maddr, mwd, rd0, rd1, eb;
      logic [7:0] mm [256];
      k = 0; own = 0; last = 1; mrw = 1; maddr = 0; mwd = 0; rd0 = 0; rd1 = 0;
      forever begin
        @(negedge CLK);
        if (!t_rst[g]) begin
          k = 0; own = 0; last = 1; mrw = 1; maddr = 0; rd0 = 0; rd1 = 0;
          for (int i = 0; i < 256; i++) mm[i] = init(i);
          chk("rst_ack0", bif.ack0, 0);
          chk("rst_ack1", bif.ack1, 0);
          chk("rst_start", bif.mem_start, 0);
          chk("rst_rw", bif.mem_rw, 1);
          chk("rst_addr", bif.mem_addr, 0);
          chk("rst_busy", bif.busy, 0);
          chk("rst_owner", bif.owner, 0);
          chk("rst_rdata0", bif.rdata0, 0);
          chk("rst_rdata1", bif.rdata1, 0);
          chk("rst_bus", bus, 8'hFF);
        end else begin
          if (k == L + 2 && mrw) begin
            if (own) rd1 = mm[maddr];
            else     rd0 = mm[maddr];
          end
          eb = 8'hFF;
          if (k >= 1 && k <= L + 1 && !mrw) eb = mwd;
          if (k >= 2 && k <= L + 1 && mrw)  eb = mm[maddr];
          chk("start", bif.mem_start, k == 1);
          chk("busy", bif.busy, k != 0);
          chk("ack0", bif.ack0, (k == L + 2) && !own);
          chk("ack1", bif.ack1, (k == L + 2) && own);
          chk("owner", bif.owner, own);
          chk("mem_rw", bif.mem_rw, mrw);
          chk("mem_addr", bif.mem_addr, maddr);
          chk("rdata0", bif.rdata0, rd0);
          chk("rdata1", bif.rdata1, rd1);
          chk("bus", bus, eb);
          if (bif.mem_start) begin n_start[g]++; bus_start[g] = bus; end
          if (bif.busy) n_busy[g]++;
          if (bif.ack0) begin n_ack0[g]++; if (g == 0) grants.push_back(0); end
          if (bif.ack1) begin n_ack1[g]++; if (g == 0) grants.push_back(1); end
          if (k == 0) begin
            if (t_req0[g] || t_req1[g]) begin
`ifdef ARB_ROUND_ROBIN_EN
              if (t_req0[g] && t_req1[g]) own = !last;
              else                        own = t_req1[g];
`else
              own = !t_req0[g];
`endif
              mrw   = own ? t_rw1[g] : t_rw0[g];
              maddr = own ? t_a1[g]  : t_a0[g];
              mwd   = own ? t_wd1[g] : t_wd0[g];
              k = 1;
            end
          end else if (k == L + 2) begin
            last = own;
            k = 0;
          end else begin
            if (k == L + 1 && !mrw) mm[maddr] = mwd;
            k++;
          end
        end
      end
    end
  end

  // one transaction on instance g, port p; lat = ack cycle minus the IDLE sample cycle
  task automatic txn(input int g, input int p, input logic rw, input logic [7:0] a,
                     input logic [7:0] d, output int lat);
    int t0;
    bit got;
    @(posedge CLK); #1;
    if (p == 0) begin t_req0[g] = 1; t_rw0[g] = rw; t_a0[g] = a; t_wd0[g] = d; end
    else        begin t_req1[g] = 1; t_rw1[g] = rw; t_a1[g] = a; t_wd1[g] = d; end
    t0 = cyc;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if ((p == 0) ? o_ack0[g] : o_ack1[g]) got = 1;
    end
    lat = cyc - t0;
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL txn_timeout: inst %0d port %0d got no ack, required one", g, p);
    end
    @(posedge CLK); #1;
    if (p == 0) t_req0[g] = 0;
    else        t_req1[g] = 0;
  endtask

  task automatic wait_start(input int g);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (o_start[g]) got = 1;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL start_timeout: inst %0d got no mem_start, required one", g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat, s0, a0, a1, b1;
    int exp_g [4];
    for (int g = 0; g < 2; g++) begin
      t_rst[g] = 0; t_req0[g] = 0; t_req1[g] = 0; t_rw0[g] = 1; t_rw1[g] = 1;
      t_a0[g] = 0; t_a1[g] = 0; t_wd0[g] = 0; t_wd1[g] = 0;
      n_start[g] = 0; n_ack0[g] = 0; n_ack1[g] = 0; n_busy[g] = 0; bus_start[g] = 0;
    end

    // reset held 3 cycles, then 10 quiet cycles
    repeat (3) @(posedge CLK);
    #1 t_rst[0] = 1; t_rst[1] = 1;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("idle_starts0", n_start[0], 0);
    chk("idle_starts1", n_start[1], 0);

    // port 0 write 0xA5 to 0x3C, then read it back
    s0 = n_start[0];
    txn(0, 0, 1'b0, 8'h3C, 8'hA5, lat);
    chk("wr_lat", lat, 3);
    chk("wr_bus_issue", bus_start[0], 8'hA5);
    txn(0, 0, 1'b1, 8'h3C, 8'h00, lat);
    chk("rd_lat", lat, 3);
    chk("rd_data", o_rd0[0], 8'hA5);
    chk("wr_rd_starts", n_start[0] - s0, 2);

    // early drop: req0 removed during WAIT, still one ack
    a0 = n_ack0[0];
    @(posedge CLK); #1 t_req0[0] = 1; t_rw0[0] = 1; t_a0[0] = 8'h44;
    wait_start(0);
    @(posedge CLK); #1 t_req0[0] = 0;
    repeat (8) @(negedge CLK);
    chk("drop_acks", n_ack0[0] - a0, 1);
    chk("drop_rdata", o_rd0[0], 8'h2A);

    // reset during WAIT of a port 1 write
    a1 = n_ack1[0];
    @(posedge CLK); #1 t_req1[0] = 1; t_rw1[0] = 0; t_a1[0] = 8'h55; t_wd1[0] = 8'hC3;
    wait_start(0);
    @(posedge CLK); #1;
    chk("wait_bus_driven", o_bus[0], 8'hC3);
    #1 t_rst[0] = 0; t_req1[0] = 0;
    #1;
    chk("abort_bus_z", o_bus[0], 8'hFF);
    chk("abort_busy", o_busy[0], 0);
    chk("abort_ack1", o_ack1[0], 0);
    repeat (2) @(posedge CLK);
    #1 t_rst[0] = 1;
    repeat (3) @(negedge CLK);
    chk("abort_no_ack1", n_ack1[0] - a1, 0);
    txn(0, 1, 1'b1, 8'h55, 8'h00, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_acks", n_ack1[0] - a1, 1);
    chk("post_rst_rdata", o_rd1[0], 8'h3B);

    // conflict: both ports read, both held high for four transactions
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    a1 = n_ack1[0];
    grants.delete();
    @(posedge CLK); #1;
    t_req0[0] = 1; t_rw0[0] = 1; t_a0[0] = 8'h20;
    t_req1[0] = 1; t_rw1[0] = 1; t_a1[0] = 8'h21;
    for (int i = 0; i < 200 && grants.size() < 4; i++) @(negedge CLK);
    @(posedge CLK); #1 t_req0[0] = 0; t_req1[0] = 0;
    if (grants.size() < 4) begin
      n_chk++; n_err++;
      $display("FAIL conflict_timeout: got %0d grants, required 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) chk($sformatf("grant%0d", i), grants[i], exp_g[i]);
    end
`ifndef ARB_ROUND_ROBIN_EN
    chk("starve_port1", n_ack1[0] - a1, 0);
`endif
    repeat (3) @(negedge CLK);

    // latency sweep on the MEM_LAT=4 instance
    b1 = n_busy[1];
    txn(1, 1, 1'b1, 8'h10, 8'h00, lat);
    chk("lat4_ack", lat, 6);
    chk("lat4_rdata", o_rd1[1], 8'h7E);
    chk("lat4_busy", n_busy[1] - b1, 6);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
